// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, FSM state codes and A-source select encodings.
// The datapath imports this package as well, so encodings stay in one place.
package cpu_defs;

  localparam logic [2:0] OpLoad  = 3'b000;
  localparam logic [2:0] OpStore = 3'b001;
  localparam logic [2:0] OpAdd   = 3'b010;
  localparam logic [2:0] OpSub   = 3'b011;
  localparam logic [2:0] OpInput = 3'b100;
  localparam logic [2:0] OpJz    = 3'b101;
  localparam logic [2:0] OpJpos  = 3'b110;
  localparam logic [2:0] OpHalt  = 3'b111;

  localparam logic [1:0] AselAlu   = 2'b00;
  localparam logic [1:0] AselInput = 2'b01;
  localparam logic [1:0] AselRam   = 2'b10;

  typedef enum logic [3:0] {
    StStart  = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StLoad   = 4'd3,
    StStore  = 4'd4,
    StAdd    = 4'd5,
    StSub    = 4'd6,
    StInput  = 4'd7,
    StJz     = 4'd8,
    StJpos   = 4'd9,
    StHalt   = 4'd10
  } state_t;

  function automatic state_t op_to_state(input logic [2:0] op);
    state_t st;
    st = StStart;
    unique case (op)
      OpLoad:  st = StLoad;
      OpStore: st = StStore;
      OpAdd:   st = StAdd;
      OpSub:   st = StSub;
      OpInput: st = StInput;
      OpJz:    st = StJz;
      OpJpos:  st = StJpos;
      OpHalt:  st = StHalt;
      default: st = StStart;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/control_outdec.sv
// Combinational output decoder for the control FSM: a pure function of state and flags.
// The one-shot Retire on HALT entry needs history, so it is added in control_unit.
module control_outdec
  import cpu_defs::*;
(
  input  state_t     state_i,
  input  logic       aeq0_i,
  input  logic       apos_i,
  input  logic       enter_i,
  output logic       ir_load_o,
  output logic       pc_load_o,
  output logic       jmp_mux_o,
  output logic       mem_inst_o,
  output logic       mem_wr_o,
  output logic       a_load_o,
  output logic       sub_o,
  output logic [1:0] a_sel_o,
  output logic       halt_o,
  output logic       retire_o
);

  always_comb begin
    ir_load_o  = 1'b0;
    pc_load_o  = 1'b0;
    jmp_mux_o  = 1'b0;
    mem_inst_o = 1'b0;
    mem_wr_o   = 1'b0;
    a_load_o   = 1'b0;
    sub_o      = 1'b0;
    a_sel_o    = AselAlu;
    halt_o     = 1'b0;
    retire_o   = 1'b0;
    unique case (state_i)
      StFetch: begin
        ir_load_o = 1'b1;
        pc_load_o = 1'b1;
      end
      StDecode: mem_inst_o = 1'b1;
      StLoad: begin
        mem_inst_o = 1'b1;
        a_sel_o    = AselRam;
        a_load_o   = 1'b1;
        retire_o   = 1'b1;
      end
      StStore: begin
        mem_inst_o = 1'b1;
        mem_wr_o   = 1'b1;
        retire_o   = 1'b1;
      end
      StAdd, StSub: begin
        mem_inst_o = 1'b1;
        a_sel_o    = AselAlu;
        sub_o      = (state_i == StSub);
        a_load_o   = 1'b1;
        retire_o   = 1'b1;
      end
      StInput: begin
        a_sel_o  = AselInput;
        a_load_o = enter_i;
        retire_o = enter_i;
      end
      StJz, StJpos: begin
        jmp_mux_o = 1'b1;
        pc_load_o = (state_i == StJz) ? aeq0_i : apos_i;
        retire_o  = 1'b1;
      end
      StHalt: halt_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Control FSM for the simple accumulator CPU: state register, next-state logic and
// retired-instruction counter; output decoding lives in control_outdec.
module control_unit
  import cpu_defs::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [2:0]       IR,
  input  logic             Aeq0,
  input  logic             Apos,
  input  logic             Enter,
  output logic             IRload,
  output logic             PCload,
  output logic             JMPmux,
  output logic             Meminst,
  output logic             MemWr,
  output logic             Aload,
  output logic             Sub,
  output logic [1:0]       Asel,
  output logic             Halt,
  output logic             Retire,
  output logic [CNT_W-1:0] InstrCount,
  output logic [3:0]       State
);

  state_t           state_q, state_d;
  logic             halted_q;
  logic [CNT_W-1:0] count_q;
  logic             dec_retire;

  control_outdec u_outdec (
    .state_i    (state_q),
    .aeq0_i     (Aeq0),
    .apos_i     (Apos),
    .enter_i    (Enter),
    .ir_load_o  (IRload),
    .pc_load_o  (PCload),
    .jmp_mux_o  (JMPmux),
    .mem_inst_o (Meminst),
    .mem_wr_o   (MemWr),
    .a_load_o   (Aload),
    .sub_o      (Sub),
    .a_sel_o    (Asel),
    .halt_o     (Halt),
    .retire_o   (dec_retire)
  );

  // HALT retires only in its first cycle; halted_q marks that it has been seen.
  assign Retire     = dec_retire | ((state_q == StHalt) & ~halted_q);
  assign InstrCount = count_q;
  assign State      = state_q;

  always_comb begin
    state_d = StStart;
    case (state_q)
      StStart:  state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: state_d = op_to_state(IR);
      StLoad, StStore, StAdd, StSub, StJz, StJpos: state_d = StFetch;
      StInput:  state_d = Enter ? StFetch : StInput;
      StHalt:   state_d = StHalt;
      default:  state_d = StStart;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= StStart;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_q == StHalt);
      if (Retire) count_q <= count_q + CNT_W'(1);
    end
  end

endmodule
